approx_adder_pipe: RTL and testbench
====================================

Name: approx_adder_pipe

Overview:
- Parametrised, pipelined successor to the partitioned 4-bit approximate adder blocks.
- Adds two WIDTH-bit operands CHUNK bits per pipeline stage, with a registered carry between stages.
- Per-transaction mode selects exact addition or lower-part-OR approximation (LOA) of the low APPROX_BITS.
- Sits between operand producers and accuracy/consumer logic under valid/ready flow control; keeps a saturating count of approximate transactions.

Parameters:
WIDTH, 16, operand and sum width; must be a multiple of CHUNK.
CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK.
APPROX_BITS, 4, low bits approximated in mode=1; range 0..WIDTH. A value of 0 makes approx mode equal exact mode.
CNT_W, 16, width of the approximate-transaction counter.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in; used in exact mode only
mode  in  1  0 = exact, 1 = approximate
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry out of bit WIDTH-1
approx_cnt  out  CNT_W  accepted mode=1 beats, saturating

Behaviour:
- Reset (sync, rst=1 at an edge): all stage-valid bits clear, out_valid=0, sum=0, cout=0, approx_cnt=0. In-flight beats are discarded. rst overrides a simultaneous accept; no beat is taken that cycle.
- Accept: a beat is taken on an edge where in_valid & in_ready.
- in_ready = ~out_valid | out_ready. The whole pipeline advances only when in_ready=1 (global stall). Bubbles advance with the pipeline.
- Pipeline registers: input register R0, then R1..R_STAGES. R_k holds bits [k*CHUNK-1:0] of the sum, the carry into chunk k, the remaining operand bits, mode and a valid bit.
- Stage k computes chunk k = a_chunk + b_chunk + carry_k.
- Latency: a beat accepted at edge T drives out_valid=1 just after edge T+STAGES, provided there is no stall. Each stall cycle adds exactly 1.
- Throughput: one beat per cycle while out_ready=1.
- Exact mode: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Approx mode with APPROX_BITS=k>0:
  - sum[k-1:0] = a[k-1:0] | b[k-1:0].
  - Carry into bit k = a[k-1] & b[k-1].
  - Bits k..WIDTH-1 and cout use exact addition with that carry. cin is ignored.
  - If k is not chunk-aligned, the chunk containing bit k applies the split inside that stage.
  - k=WIDTH gives sum = a|b and cout = a[W-1]&b[W-1].
- mode travels with its beat. Mixed-mode back-to-back beats are legal and independent.
- Output hold: sum, cout and out_valid stay stable while out_valid & ~out_ready. No beat is lost or duplicated.
- When out_valid=0, sum and cout keep their last value; the bench must not check them then.
- approx_cnt increments on each accepted mode=1 beat and saturates at 2^CNT_W-1. It does not wrap.
- Invalid parameters (WIDTH%CHUNK≠0, APPROX_BITS>WIDTH) must fail at elaboration.

Test Plan:
- Exact carry ripple. a=0x00FF, b=0x0001, cin=0, mode=0, out_ready=1. Expect sum=0x0100, cout=0, out_valid 4 edges after accept, approx_cnt=0.
- Wrap-around. a=0xFFFF, b=0x0001, cin=0, mode=0. Expect sum=0x0000, cout=1. Repeat with a=0xFFFF, b=0xFFFF, cin=1: expect sum=0xFFFF, cout=1.
- LOA approx. mode=1, a=0x000F, b=0x0001. Expect sum=0x000F (exact would be 0x0010), cout=0. Then a=0x0008, b=0x0008, cin=1: expect sum=0x0018, cin ignored. approx_cnt=2.
- Backpressure. Send 6 back-to-back beats with alternating mode. Drive out_ready=0 for 3 cycles once the first result appears. Expect in_ready=0 exactly during the stall, held sum/cout stable, and all 6 results in order with no duplicates.
- Reset mid-operation. With 3 beats in flight, assert rst for 1 cycle together with in_valid=1. Expect out_valid=0 after that edge, no results from the flushed beats, approx_cnt=0, and the first post-reset beat appearing with normal latency.
- Counter saturation, using CNT_W=2. Accept 5 mode=1 beats. Expect approx_cnt sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/approx_adder_pipe.sv
// Pipelined WIDTH-bit adder, CHUNK bits per stage with a registered carry between stages.
// Each beat chooses exact addition or lower-part-OR approximation of the low APPROX_BITS.
module approx_adder_pipe #(
   parameter int WIDTH       = 16,
   parameter int CHUNK       = 4,
   parameter int APPROX_BITS = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [CNT_W-1:0] approx_cnt
);

   localparam int STAGES = WIDTH / CHUNK;

   if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("approx_adder_pipe: WIDTH must be a positive multiple of CHUNK");
   end
   if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
      $error("approx_adder_pipe: APPROX_BITS must lie in 0..WIDTH");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("approx_adder_pipe: CNT_W must be at least 1");
   end

   // Handshake: a beat moves on an edge where valid & ready; a valid producer holds
   // its data until accepted, and ready never depends on the same-side valid.
   // The whole pipeline advances as one unit whenever the output slot frees up.
   logic advance;

   // Stage register k holds the operands, the partial sum of chunks below k,
   // the carry into chunk k, the beat's mode and its valid bit.
   logic [WIDTH-1:0] a_q    [STAGES];
   logic [WIDTH-1:0] b_q    [STAGES];
   logic [WIDTH-1:0] psum_q [STAGES];
   logic [WIDTH-1:0] psum_d [STAGES];
   logic [STAGES-1:0] carry_q;
   logic [STAGES-1:0] carry_d;
   logic [STAGES-1:0] mode_q;
   logic [STAGES-1:0] vld_q;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign advance    = ~out_valid_q | out_ready;
   assign in_ready   = advance;
   assign out_valid  = out_valid_q;
   assign sum        = sum_q;
   assign cout       = cout_q;
   assign approx_cnt = cnt_q;

   // Inside the approximated region the carry chain restarts at its top bit, so a
   // chunk straddling APPROX_BITS splits naturally within one stage.
   always_comb begin : stage_math
      logic c_w;
      c_w = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         psum_d[k] = psum_q[k];
         c_w       = carry_q[k];
         for (int i = 0; i < CHUNK; i++) begin
            if (mode_q[k] && ((k * CHUNK + i) < APPROX_BITS)) begin
               psum_d[k][k*CHUNK+i] = a_q[k][k*CHUNK+i] | b_q[k][k*CHUNK+i];
               c_w = ((k * CHUNK + i) == (APPROX_BITS - 1)) ?
                     (a_q[k][k*CHUNK+i] & b_q[k][k*CHUNK+i]) : 1'b0;
            end else begin
               psum_d[k][k*CHUNK+i] = a_q[k][k*CHUNK+i] ^ b_q[k][k*CHUNK+i] ^ c_w;
               c_w = (a_q[k][k*CHUNK+i] & b_q[k][k*CHUNK+i]) |
                     (c_w & (a_q[k][k*CHUNK+i] ^ b_q[k][k*CHUNK+i]));
            end
         end
         carry_d[k] = c_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q       <= '0;
         carry_q     <= '0;
         mode_q      <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]    <= '0;
            b_q[k]    <= '0;
            psum_q[k] <= '0;
         end
      end else if (advance) begin
         vld_q[0] <= in_valid;
         if (in_valid) begin
            a_q[0]     <= a;
            b_q[0]     <= b;
            psum_q[0]  <= '0;
            carry_q[0] <= cin;
            mode_q[0]  <= mode;
         end
         for (int k = 1; k < STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               a_q[k]     <= a_q[k-1];
               b_q[k]     <= b_q[k-1];
               psum_q[k]  <= psum_d[k-1];
               carry_q[k] <= carry_d[k-1];
               mode_q[k]  <= mode_q[k-1];
            end
         end
         // Bubbles leave the last result in place so sum/cout keep their old value.
         out_valid_q <= vld_q[STAGES-1];
         if (vld_q[STAGES-1]) begin
            sum_q  <= psum_d[STAGES-1];
            cout_q <= carry_d[STAGES-1];
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (in_valid && advance && mode && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed bench for approx_adder_pipe: exact/LOA results, latency, stall hold,
// mid-flight reset and counter saturation on a second CNT_W=2 instance.
module tb_approx_adder_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_s;
   logic [15:0] b_s;
   logic        cin_s;
   logic        mode_s;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum_s;
   logic        cout_s;
   logic [15:0] cnt_s;

   logic        in_valid2;
   logic        in_ready2;
   logic        out_valid2;
   logic [15:0] sum2;
   logic        cout2;
   logic [1:0]  cnt2;

   int checks = 0;
   int errors = 0;

   logic [16:0] exp_q[$];

   approx_adder_pipe #(.WIDTH(16), .CHUNK(4), .APPROX_BITS(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a_s), .b(b_s), .cin(cin_s), .mode(mode_s),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum_s), .cout(cout_s), .approx_cnt(cnt_s)
   );

   approx_adder_pipe #(.WIDTH(16), .CHUNK(4), .APPROX_BITS(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(16'h0003), .b(16'h0005), .cin(1'b0), .mode(1'b1),
      .out_valid(out_valid2), .out_ready(1'b1),
      .sum(sum2), .cout(cout2), .approx_cnt(cnt2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Single beat through an empty pipeline: checks latency, result and no duplicate.
   task automatic send_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tc, input logic tm,
                           input logic [15:0] es, input logic ec);
      a_s = ta; b_s = tb; cin_s = tc; mode_s = tm; in_valid = 1'b1;
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk({tag, "_latency"}, 32'(out_valid), 32'd0);
      end
      cyc();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(sum_s), 32'(es));
      chk({tag, "_cout"}, 32'(cout_s), 32'(ec));
      cyc();
      chk({tag, "_no_dup"}, 32'(out_valid), 32'd0);
   endtask

   logic [15:0] bp_a [6];
   logic [15:0] bp_b [6];
   logic        bp_c [6];
   logic        bp_m [6];
   int          sat_exp [5];

   initial begin
      int sent;
      int got;
      int stall_left;
      int cycles;
      bit seen;

      rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
      a_s = '0; b_s = '0; cin_s = 1'b0; mode_s = 1'b0;
      cyc();
      cyc();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum_s), 32'd0);
      chk("rst_cout", 32'(cout_s), 32'd0);
      chk("rst_cnt", 32'(cnt_s), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      send_one("ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
      chk("ripple_cnt", 32'(cnt_s), 32'd0);
      send_one("wrap1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
      send_one("wrap2", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
      send_one("loa1", 16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0);
      send_one("loa2", 16'h0008, 16'h0008, 1'b1, 1'b1, 16'h0018, 1'b0);
      chk("loa_cnt", 32'(cnt_s), 32'd2);

      // Backpressure: six beats, alternating mode, three-cycle stall on first result.
      bp_a[0] = 16'h1234; bp_b[0] = 16'h1111; bp_c[0] = 1'b0; bp_m[0] = 1'b0;
      bp_a[1] = 16'h00F3; bp_b[1] = 16'h0005; bp_c[1] = 1'b0; bp_m[1] = 1'b1;
      bp_a[2] = 16'h8000; bp_b[2] = 16'h8000; bp_c[2] = 1'b1; bp_m[2] = 1'b0;
      bp_a[3] = 16'h0F0F; bp_b[3] = 16'h0109; bp_c[3] = 1'b1; bp_m[3] = 1'b1;
      bp_a[4] = 16'hFFFF; bp_b[4] = 16'h0000; bp_c[4] = 1'b1; bp_m[4] = 1'b0;
      bp_a[5] = 16'hFFFF; bp_b[5] = 16'hFFFF; bp_c[5] = 1'b0; bp_m[5] = 1'b1;
      exp_q.push_back(17'h02345);
      exp_q.push_back(17'h000F7);
      exp_q.push_back(17'h10001);
      exp_q.push_back(17'h0101F);
      exp_q.push_back(17'h10000);
      exp_q.push_back(17'h1FFFF);

      sent = 0; got = 0; stall_left = 0; cycles = 0; seen = 1'b0;
      while (got < 6 && cycles < 60) begin
         if (!seen && out_valid) begin
            seen = 1'b1;
            stall_left = 3;
         end
         out_ready = (stall_left == 0);
         in_valid  = (sent < 6);
         if (sent < 6) begin
            a_s = bp_a[sent]; b_s = bp_b[sent]; cin_s = bp_c[sent]; mode_s = bp_m[sent];
         end
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'(stall_left == 0));
         if (stall_left > 0) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'({cout_s, sum_s}), 32'(exp_q[0]));
            stall_left--;
         end else if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("bp_extra_result", 32'(out_valid), 32'd0);
            end else begin
               chk("bp_result", 32'({cout_s, sum_s}), 32'(exp_q.pop_front()));
               got++;
            end
         end
         if (in_valid && in_ready) sent++;
         cycles++;
         cyc();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_results", 32'(got), 32'd6);
      chk("bp_drained", 32'(out_valid), 32'd0);
      chk("bp_cnt", 32'(cnt_s), 32'd5);

      // Reset with three approximate beats in flight and a beat offered on the reset edge.
      mode_s = 1'b1; cin_s = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_s = 16'(i + 1); b_s = 16'h0010;
         cyc();
      end
      chk("pre_rst_cnt", 32'(cnt_s), 32'd8);
      rst = 1'b1;
      a_s = 16'h0777;
      cyc();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_cnt", 32'(cnt_s), 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("flushed_no_output", 32'(out_valid), 32'd0);
      end
      chk("post_rst_cnt", 32'(cnt_s), 32'd0);
      send_one("post_rst", 16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0);

      // Saturation on the CNT_W=2 instance.
      sat_exp = '{1, 2, 3, 3, 3};
      chk("sat_start", 32'(cnt2), 32'd0);
      in_valid2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("sat_cnt", 32'(cnt2), 32'(sat_exp[i]));
      end
      in_valid2 = 1'b0;

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
